// File: rtl/dram_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states
// and the load lane-extract helper.
package dram_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Legal size code and natural alignment for that size.
  function automatic logic req_legal(input logic [2:0] ctrl, input logic [1:0] off);
    case (ctrl)
      F3_B, F3_BU: req_legal = 1'b1;
      F3_H, F3_HU: req_legal = ~off[0];
      F3_W:        req_legal = (off == 2'b00);
      default:     req_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  ctrl);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (ctrl)
      F3_B:    lane_extract = {{24{b[7]}}, b};
      F3_BU:   lane_extract = {24'd0, b};
      F3_H:    lane_extract = {{16{h[15]}}, h};
      F3_HU:   lane_extract = {16'd0, h};
      default: lane_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/dram_responder_lane.sv
// Combinational byte-lane logic: load extract/extend and store replicate/mask.
module dram_responder_lane
  import dram_responder_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  ctrl,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data,
  output logic [3:0]  wmask
);

  always_comb begin
    load_data = lane_extract(rdata, off, ctrl);
    case (ctrl[1:0])
      2'b00: begin
        store_data = {4{wdata[7:0]}};
        wmask      = 4'b0001 << off;
      end
      2'b01: begin
        store_data = {2{wdata[15:0]}};
        wmask      = 4'b0011 << {off[1], 1'b0};
      end
      default: begin
        store_data = wdata;
        wmask      = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/dram_responder.sv
// CPU-side load/store responder in front of a word-addressed backing memory,
// with alignment checking, timeout abort and a sticky per-request error flag.
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int MEM_AW      = 30
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       w_dram_addr,
  input  logic [31:0]       w_dram_wdata,
  input  logic [2:0]        w_dram_ctrl,
  input  logic              w_dram_le,
  input  logic              w_dram_we_t,
  output logic              w_dram_busy,
  output logic [31:0]       w_dram_odata,
  output logic              w_dram_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        pend_q, pend_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] odata_q, odata_d;
  logic [15:0] cnt_q, cnt_d;

  logic        strobe;
  logic [31:0] lane_load, lane_store;
  logic [3:0]  lane_mask;

  assign strobe = w_dram_le | w_dram_we_t;

  dram_responder_lane u_lane (
    .off        (addr_q[1:0]),
    .ctrl       (ctrl_q),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .load_data  (lane_load),
    .store_data (lane_store),
    .wmask      (lane_mask)
  );

  // Memory handshake: mem_req is held with all fields stable until the cycle
  // mem_ack is sampled high; any mem_ack seen outside ISSUE/WAIT is discarded.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    err_d   = err_q;
    pend_d  = pend_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ctrl_d  = ctrl_q;
    odata_d = odata_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (strobe) begin
          addr_d  = w_dram_addr;
          wdata_d = w_dram_wdata;
          ctrl_d  = w_dram_ctrl;
          req_d   = req_legal(w_dram_ctrl, w_dram_addr[1:0]);
          we_d    = w_dram_we_t & req_legal(w_dram_ctrl, w_dram_addr[1:0]);
          busy_d  = 1'b1;
          err_d   = 1'b0;
          pend_d  = w_dram_le & w_dram_we_t;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
        if (!req_q) begin
          pend_d  = 1'b1;
          state_d = S_DONE;
        end else if (mem_ack) begin
          req_d   = 1'b0;
          if (!we_q) odata_d = lane_load;
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          if (!we_q) odata_d = lane_load;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          pend_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        err_d   = pend_q | strobe;
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A strobe while busy is dropped but remembered as an error.
    if (busy_q && strobe && state_q != S_DONE) pend_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ctrl_q  <= '0;
      odata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ctrl_q  <= ctrl_d;
      odata_q <= odata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign w_dram_busy  = busy_q;
  assign w_dram_odata = odata_q;
  assign w_dram_err   = err_q;
  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q[MEM_AW+1:2];
  assign mem_wdata    = lane_store;
  assign mem_wmask    = we_q ? lane_mask : 4'b0000;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: directed vectors plus randomized loads/stores
// against an arithmetic reference model of the lane and error rules.
module tb_dram_responder;
  import dram_responder_pkg::*;

  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] w_dram_addr = '0;
  logic [31:0] w_dram_wdata = '0;
  logic [2:0]  w_dram_ctrl = '0;
  logic        w_dram_le = 1'b0;
  logic        w_dram_we_t = 1'b0;
  logic        w_dram_busy;
  logic [31:0] w_dram_odata;
  logic        w_dram_err;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  dbg_state;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_odata = '0;

  logic [2:0]  ld_codes [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
  logic [2:0]  st_codes [3] = '{3'b000, 3'b001, 3'b010};
  int          r_sel, r_dly, r_extra;
  logic        r_ld, r_st;
  logic [2:0]  r_c;
  logic [31:0] r_a;

  always #5 CLK = ~CLK;

  dram_responder #(.TIMEOUT_CYC(TO), .MEM_AW(30)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .w_dram_addr  (w_dram_addr),
    .w_dram_wdata (w_dram_wdata),
    .w_dram_ctrl  (w_dram_ctrl),
    .w_dram_le    (w_dram_le),
    .w_dram_we_t  (w_dram_we_t),
    .w_dram_busy  (w_dram_busy),
    .w_dram_odata (w_dram_odata),
    .w_dram_err   (w_dram_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .dbg_state    (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: sizes in bytes, shifts and arithmetic extension.
  function automatic logic legal_m(input logic [2:0] c, input logic [31:0] a);
    int bytes;
    case (c)
      3'b000, 3'b100: bytes = 1;
      3'b001, 3'b101: bytes = 2;
      3'b010:         bytes = 4;
      default:        return 1'b0;
    endcase
    return (a % bytes) == 0;
  endfunction

  function automatic logic [31:0] load_m(input logic [31:0] word, input logic [31:0] a,
                                         input logic [2:0] c);
    logic [31:0] v;
    int b, h;
    v = word >> (8 * (a % 4));
    b = int'(v % 256);
    h = int'(v % 65536);
    case (c)
      3'b000:  return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'b100:  return 32'(b);
      3'b001:  return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'b101:  return 32'(h);
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] mask_m(input logic [2:0] c, input logic [31:0] a);
    case (c)
      3'b000:  return 32'(1 << (a % 4));
      3'b001:  return 32'(3 << (a % 4));
      default: return 32'hF;
    endcase
  endfunction

  function automatic logic [31:0] wdata_m(input logic [2:0] c, input logic [31:0] d);
    case (c)
      3'b000:  return (d % 256) * 32'h0101_0101;
      3'b001:  return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // dly: number of request cycles before mem_ack (-1 = never).
  // extra: busy-cycle index at which a stray load strobe is injected (-1 = none).
  task automatic run_op(input string tag, input logic ld, input logic st, input logic [2:0] c,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                        input int dly, input int extra);
    logic legal, is_load, exp_err;
    int   exp_busy, exp_nreq;
    int   nbusy = 0;
    int   nreq = 0;
    legal    = legal_m(c, a);
    is_load  = ld && !st;
    exp_busy = !legal ? 2 : (dly < 0 ? TO + 2 : dly + 2);
    exp_nreq = legal ? exp_busy - 1 : 0;
    exp_err  = !legal || (ld && st) || (extra >= 0) || (legal && dly < 0);
    if (legal && is_load && dly >= 0) model_odata = load_m(rd, a, c);
    exp_q.push_back(model_odata);
    w_dram_le    = ld;
    w_dram_we_t  = st;
    w_dram_ctrl  = c;
    w_dram_addr  = a;
    w_dram_wdata = d;
    step();
    w_dram_le    = 1'b0;
    w_dram_we_t  = 1'b0;
    w_dram_addr  = $urandom;
    w_dram_wdata = $urandom;
    w_dram_ctrl  = 3'($urandom);
    for (int i = 0; i < 200 && w_dram_busy === 1'b1; i++) begin
      if (i == extra) w_dram_le = 1'b1;
      if (mem_req === 1'b1) begin
        check($sformatf("%s.mem_addr", tag), 32'(mem_addr), {2'b00, a[31:2]});
        check($sformatf("%s.mem_we", tag), 32'(mem_we), 32'(st));
        if (st) begin
          check($sformatf("%s.mem_wmask", tag), 32'(mem_wmask), mask_m(c, a));
          check($sformatf("%s.mem_wdata", tag), mem_wdata, wdata_m(c, d));
        end
        if (nreq == dly) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end
        nreq++;
      end
      nbusy++;
      step();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      w_dram_le = 1'b0;
    end
    check($sformatf("%s.busy_cycles", tag), 32'(nbusy), 32'(exp_busy));
    check($sformatf("%s.req_cycles", tag), 32'(nreq), 32'(exp_nreq));
    check($sformatf("%s.odata", tag), w_dram_odata, exp_q.pop_front());
    check($sformatf("%s.err", tag), 32'(w_dram_err), 32'(exp_err));
  endtask

  initial begin
    step();
    step();
    check("rst.busy", 32'(w_dram_busy), 32'd0);
    check("rst.odata", w_dram_odata, 32'd0);
    check("rst.err", 32'(w_dram_err), 32'd0);
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_wmask", 32'(mem_wmask), 32'd0);
    check("rst.state", 32'(dbg_state), 32'(S_IDLE));
    RST = 1'b0;

    run_op("lb_103", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, -1);
    check("lb_103.value", w_dram_odata, 32'hFFFF_FF80);
    run_op("lhu_102", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_1234, 2, -1);
    check("lhu_102.value", w_dram_odata, 32'h0000_80FF);
    run_op("sh_206", 1'b0, 1'b1, 3'b001, 32'h206, 32'h0000_ABCD, 32'h0, 1, -1);
    run_op("lw_001", 1'b1, 1'b0, 3'b010, 32'h001, 32'h0, 32'h1111_1111, 0, -1);
    run_op("timeout", 1'b1, 1'b0, 3'b010, 32'h040, 32'h0, 32'h2222_2222, -1, -1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h3333_3333;
    step();
    mem_ack   = 1'b0;
    step();
    check("late_ack.odata", w_dram_odata, model_odata);
    check("late_ack.busy", 32'(w_dram_busy), 32'd0);
    check("late_ack.mem_req", 32'(mem_req), 32'd0);
    run_op("collide", 1'b1, 1'b1, 3'b010, 32'h080, 32'hCAFE_F00D, 32'h4444_4444, 0, -1);
    run_op("stray", 1'b1, 1'b0, 3'b001, 32'h0C2, 32'h0, 32'h8765_4321, 3, 1);
    run_op("clean", 1'b1, 1'b0, 3'b100, 32'h0C1, 32'h0, 32'h8765_4321, 1, -1);

    for (int k = 0; k < 24; k++) begin
      r_sel = $urandom_range(0, 9);
      r_st  = (r_sel < 4);
      r_ld  = !r_st || (r_sel == 0);
      r_c   = r_st ? st_codes[$urandom_range(0, 2)] : ld_codes[$urandom_range(0, 5)];
      r_a   = $urandom;
      if ($urandom_range(0, 1) == 1) r_a[1:0] = 2'b00;
      r_dly   = (r_sel == 9) ? -1 : $urandom_range(0, 6);
      r_extra = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 1) : -1;
      run_op($sformatf("rnd%0d", k), r_ld, r_st, r_c, r_a, $urandom, $urandom, r_dly, r_extra);
    end

    run_op("pre_rst", 1'b1, 1'b0, 3'b001, 32'h011, 32'h0, 32'h0, 0, -1);
    #2 RST = 1'b1;
    #1;
    check("rst_idle.err", 32'(w_dram_err), 32'd0);
    check("rst_idle.odata", w_dram_odata, 32'd0);
    model_odata = '0;
    step();
    RST = 1'b0;

    w_dram_le   = 1'b1;
    w_dram_ctrl = 3'b010;
    w_dram_addr = 32'h100;
    step();
    w_dram_le = 1'b0;
    step();
    step();
    check("rst_wait.pre_req", 32'(mem_req), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("rst_wait.busy", 32'(w_dram_busy), 32'd0);
    check("rst_wait.mem_req", 32'(mem_req), 32'd0);
    check("rst_wait.err", 32'(w_dram_err), 32'd0);
    check("rst_wait.state", 32'(dbg_state), 32'(S_IDLE));
    step();
    RST = 1'b0;
    step();
    check("post_rst.mem_req", 32'(mem_req), 32'd0);
    run_op("recover", 1'b1, 1'b0, 3'b000, 32'h202, 32'h0, 32'h0055_7F00, 2, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
